// File: rtl/ex_mem_reg_if.sv
// EX/MEM pipeline register bundle: EX-side results and stall/flush in, MEM-side fields and MADD/MSUB feedback out.
// master = EX stage / stall controller side, slave = the pipeline register itself.
interface ex_mem_reg_if #(
  parameter int REG_W   = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 8,
  parameter int CNT_W   = 32
);
  logic                 stall_ex;
  logic                 stall_mem;
  logic                 flush;
  logic [ADDR_W-1:0]    ex_wd;
  logic                 ex_wreg;
  logic [REG_W-1:0]     ex_wdata;
  logic [REG_W-1:0]     ex_hi;
  logic [REG_W-1:0]     ex_lo;
  logic                 ex_enhilo;
  logic [ALUOP_W-1:0]   ex_aluop;
  logic [REG_W-1:0]     ex_mem_addr;
  logic [REG_W-1:0]     ex_reg2;
  logic [2*REG_W-1:0]   hilo_i;
  logic [1:0]           cnt_i;
  logic [ADDR_W-1:0]    mem_wd;
  logic                 mem_wreg;
  logic [REG_W-1:0]     mem_wdata;
  logic [REG_W-1:0]     mem_hi;
  logic [REG_W-1:0]     mem_lo;
  logic                 mem_enhilo;
  logic [ALUOP_W-1:0]   mem_aluop;
  logic [REG_W-1:0]     mem_mem_addr;
  logic [REG_W-1:0]     mem_reg2;
  logic [2*REG_W-1:0]   hilo_o;
  logic [1:0]           cnt_o;
  logic [CNT_W-1:0]     bubble_cnt;

  modport master (
    output stall_ex, stall_mem, flush, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo,
           ex_enhilo, ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_enhilo, mem_aluop,
           mem_mem_addr, mem_reg2, hilo_o, cnt_o, bubble_cnt
  );

  modport slave (
    input  stall_ex, stall_mem, flush, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo,
           ex_enhilo, ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_enhilo, mem_aluop,
           mem_mem_addr, mem_reg2, hilo_o, cnt_o, bubble_cnt
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: 1-cycle latency; flush > bubble > advance > hold priority,
// holds everything when both stages stall, and returns the MADD/MSUB partial result to EX during a bubble.
module ex_mem_reg #(
  parameter int REG_W   = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 8,
  parameter int CNT_W   = 32
) (
  input logic         clk,
  input logic         rst,
  ex_mem_reg_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0]  wd;
    logic               wreg;
    logic [REG_W-1:0]   wdata;
    logic [REG_W-1:0]   hi;
    logic [REG_W-1:0]   lo;
    logic               enhilo;
    logic [ALUOP_W-1:0] aluop;
    logic [REG_W-1:0]   mem_addr;
    logic [REG_W-1:0]   reg2;
  } stage_t;

  stage_t             ex_stage;
  stage_t             stage_q;
  logic [2*REG_W-1:0] hilo_q;
  logic [1:0]         cnt_q;
  logic [CNT_W-1:0]   bubble_q;
  logic               bubble;

  // r0 is hardwired to zero, so a write to it is dropped before it reaches MEM.
  always_comb begin
    ex_stage          = '0;
    ex_stage.wd       = bus.ex_wd;
    ex_stage.wreg     = bus.ex_wreg && (bus.ex_wd != '0);
    ex_stage.wdata    = bus.ex_wdata;
    ex_stage.hi       = bus.ex_hi;
    ex_stage.lo       = bus.ex_lo;
    ex_stage.enhilo   = bus.ex_enhilo;
    ex_stage.aluop    = bus.ex_aluop;
    ex_stage.mem_addr = bus.ex_mem_addr;
    ex_stage.reg2     = bus.ex_reg2;
  end

  assign bubble = bus.stall_ex && !bus.stall_mem;

  // stall_ex=0 with stall_mem=1 never comes from the stall controller; it falls into the advance branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q  <= '0;
      hilo_q   <= '0;
      cnt_q    <= '0;
      bubble_q <= '0;
    end else if (bus.flush) begin
      stage_q  <= '0;
      hilo_q   <= '0;
      cnt_q    <= '0;
    end else if (bubble) begin
      stage_q  <= '0;
      hilo_q   <= bus.hilo_i;
      cnt_q    <= bus.cnt_i;
      if (bubble_q != '1) begin
        bubble_q <= bubble_q + 1'b1;
      end
    end else if (!bus.stall_ex) begin
      stage_q  <= ex_stage;
      hilo_q   <= '0;
      cnt_q    <= '0;
    end
  end

  assign bus.mem_wd       = stage_q.wd;
  assign bus.mem_wreg     = stage_q.wreg;
  assign bus.mem_wdata    = stage_q.wdata;
  assign bus.mem_hi       = stage_q.hi;
  assign bus.mem_lo       = stage_q.lo;
  assign bus.mem_enhilo   = stage_q.enhilo;
  assign bus.mem_aluop    = stage_q.aluop;
  assign bus.mem_mem_addr = stage_q.mem_addr;
  assign bus.mem_reg2     = stage_q.reg2;
  assign bus.hilo_o       = hilo_q;
  assign bus.cnt_o        = cnt_q;
  assign bus.bubble_cnt   = bubble_q;

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage of the flowCPU MIPS32 core.
- Captures EX results (GPR writeback, HI/LO writeback, load/store info) and presents them to MEM one cycle later.
- Handles stall, bubble insertion and flush.
- Carries the two-cycle MADD/MSUB intermediate (hilo_temp, cnt) back to EX while EX is stalled.
- Keeps a saturating count of inserted bubbles for debug.

Parameters:
- REG_W, 32, GPR/HI/LO data width
- ADDR_W, 5, GPR address width
- ALUOP_W, 8, aluop field width
- CNT_W, 32, bubble counter width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous active-low reset
- stall_ex  in  1  EX stage stalled this cycle
- stall_mem  in  1  MEM stage stalled this cycle
- flush  in  1  exception flush, clears the stage
- ex_wd  in  ADDR_W  GPR write address from EX
- ex_wreg  in  1  GPR write enable from EX
- ex_wdata  in  REG_W  GPR write data from EX
- ex_hi  in  REG_W  HI write value
- ex_lo  in  REG_W  LO write value
- ex_enhilo  in  1  HI/LO write enable
- ex_aluop  in  ALUOP_W  operation code, used by MEM for loads/stores
- ex_mem_addr  in  REG_W  effective memory address
- ex_reg2  in  REG_W  store data
- hilo_i  in  2*REG_W  MADD/MSUB partial product from EX
- cnt_i  in  2  MADD/MSUB cycle count from EX
- mem_wd  out  ADDR_W  registered ex_wd
- mem_wreg  out  1  registered write enable
- mem_wdata  out  REG_W  registered write data
- mem_hi  out  REG_W  registered HI value
- mem_lo  out  REG_W  registered LO value
- mem_enhilo  out  1  registered HI/LO write enable
- mem_aluop  out  ALUOP_W  registered aluop
- mem_mem_addr  out  REG_W  registered memory address
- mem_reg2  out  REG_W  registered store data
- hilo_o  out  2*REG_W  partial product returned to EX
- cnt_o  out  2  cycle count returned to EX
- bubble_cnt  out  CNT_W  number of bubbles inserted, saturating

Behaviour:
- Reset: rst low clears every output to 0 immediately, independent of clk, including bubble_cnt. On release, the first active edge behaves normally.
- All other updates happen on the rising clk edge. The priority order below is fixed.
- Priority 1, flush=1:
  - All mem_* outputs become 0 (NOP).
  - hilo_o and cnt_o become 0.
  - bubble_cnt is unchanged.
  - Flush overrides any stall.
- Priority 2, stall_ex=1 and stall_mem=0 (bubble):
  - mem_* outputs become 0.
  - hilo_o <= hilo_i and cnt_o <= cnt_i. This preserves the MADD/MSUB first-cycle result.
  - bubble_cnt increments by 1 and saturates at all-ones.
- Priority 3, stall_ex=0 (advance):
  - mem_* <= ex_*.
  - mem_wreg <= ex_wreg AND (ex_wd != 0). A write to r0 is suppressed here.
  - hilo_o and cnt_o become 0.
  - stall_ex=0 with stall_mem=1 is illegal. The stall controller never produces it; if seen, the block treats it as advance.
- Priority 4, stall_ex=1 and stall_mem=1 (hold): every register, including hilo_o, cnt_o and bubble_cnt, keeps its value.
- Latency: exactly 1 cycle from the ex_* inputs to the mem_* outputs when advancing.
- No combinational path from any input to any output.
- HI/LO fields pass through unmodified, as 32-bit words. mem_hi and mem_lo are meaningful only when mem_enhilo=1, but are registered regardless.
- Reset asserted in the middle of a hold or bubble sequence discards all state. hilo_o=0 and cnt_o=0, so EX restarts any MADD/MSUB from cnt 0.

Test Plan:
- Reset: drive rst=0 with random inputs, no clk edge -> all outputs 0 at once. Release, then advance with ex_wd=5, ex_wreg=1, ex_wdata=0x12345678 -> next edge gives mem_wd=5, mem_wreg=1, mem_wdata=0x12345678.
- r0 suppression: advance with ex_wd=0, ex_wreg=1, ex_wdata=0xFFFFFFFF -> mem_wreg=0, mem_wdata=0xFFFFFFFF.
- MADD bubble: stall_ex=1, stall_mem=0, hilo_i=0x00000001_00000002, cnt_i=1 -> mem_wreg=0, mem_enhilo=0, hilo_o=0x00000001_00000002, cnt_o=1, bubble_cnt=1. Next cycle advance with ex_enhilo=1, ex_hi=7 -> mem_hi=7, mem_enhilo=1, cnt_o=0, hilo_o=0.
- Hold: load a value (mem_wdata=0xA5A5A5A5), then stall_ex=1 and stall_mem=1 for 3 cycles with changing inputs -> mem_wdata stays 0xA5A5A5A5 and bubble_cnt is unchanged.
- Flush during stall: stall_ex=1, stall_mem=1, flush=1 -> all mem_* outputs, hilo_o and cnt_o become 0; bubble_cnt is unchanged.
- Saturation: preload so bubble_cnt=0xFFFFFFFE, then 3 bubble cycles -> 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFFFF. Assert rst=0 mid-sequence -> bubble_cnt=0 immediately.
